// File: rtl/spi_cs_router_if.sv
// Signal bundle for spi_cs_router: host SPI pins, target SPI pins and status/control.
// The router takes the slave modport; the host side or bench takes master.
interface spi_cs_router_if #(
    parameter int G_CS_COUNT = 2,
    parameter int G_CNT_W    = 16
);
    logic                  p_in_spi_clk;
    logic [G_CS_COUNT-1:0] p_in_spi_cs;
    logic                  p_in_spi_mosi;
    logic                  p_out_spi_miso;
    logic                  p_out_tgt_clk;
    logic [G_CS_COUNT-1:0] p_out_tgt_cs;
    logic                  p_out_tgt_mosi;
    logic [G_CS_COUNT-1:0] p_in_tgt_miso;
    logic [G_CS_COUNT-1:0] p_out_active;
    logic                  p_out_xfer_done;
    logic [G_CNT_W-1:0]    p_out_bit_cnt;
    logic                  p_out_err_multi;
    logic                  p_out_err_timeout;
    logic                  p_in_err_clr;

    modport slave (
        input  p_in_spi_clk, p_in_spi_cs, p_in_spi_mosi, p_in_tgt_miso, p_in_err_clr,
        output p_out_spi_miso, p_out_tgt_clk, p_out_tgt_cs, p_out_tgt_mosi,
               p_out_active, p_out_xfer_done, p_out_bit_cnt,
               p_out_err_multi, p_out_err_timeout
    );

    modport master (
        output p_in_spi_clk, p_in_spi_cs, p_in_spi_mosi, p_in_tgt_miso, p_in_err_clr,
        input  p_out_spi_miso, p_out_tgt_clk, p_out_tgt_cs, p_out_tgt_mosi,
               p_out_active, p_out_xfer_done, p_out_bit_cnt,
               p_out_err_multi, p_out_err_timeout
    );
endinterface

// File: rtl/spi_cs_router.sv
// Oversampling SPI pass-through: one host port routed to one of G_CS_COUNT targets,
// with collision detection, stall timeout, per-transaction bit counting and sticky errors.
module spi_cs_router #(
    parameter int G_CS_COUNT    = 2,
    parameter int G_SYNC_STAGES = 2,
    parameter int G_TIMEOUT     = 4096,
    parameter int G_CNT_W       = 16
) (
    input  logic           p_in_clk,
    input  logic           p_in_rst,
    spi_cs_router_if.slave bus
);
    localparam int SEL_W = (G_CS_COUNT > 1) ? $clog2(G_CS_COUNT) : 1;
    localparam int TO_W  = $clog2(G_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_BLOCK  = 2'd2;

    function automatic int unsigned count_low(input logic [G_CS_COUNT-1:0] cs);
        count_low = 0;
        for (int i = 0; i < G_CS_COUNT; i++)
            if (!cs[i]) count_low++;
    endfunction

    function automatic logic [SEL_W-1:0] first_low(input logic [G_CS_COUNT-1:0] cs);
        first_low = '0;
        for (int i = G_CS_COUNT - 1; i >= 0; i--)
            if (!cs[i]) first_low = SEL_W'(i);
    endfunction

    logic [G_SYNC_STAGES-1:0] sclk_sync;
    logic [G_SYNC_STAGES-1:0] mosi_sync;
    logic [G_CS_COUNT-1:0]    cs_sync [G_SYNC_STAGES];
    logic                     sclk_prev;

    logic [G_CS_COUNT-1:0] cs_s;
    logic                  sclk_s;
    logic                  mosi_s;
    logic                  sclk_rise;

    logic [1:0]            state;
    logic [SEL_W-1:0]      sel;
    logic [SEL_W-1:0]      new_sel;
    logic [G_CS_COUNT-1:0] sel_mask;
    logic [G_CS_COUNT-1:0] new_mask;
    logic [G_CNT_W-1:0]    bit_acc;
    logic [TO_W-1:0]       tout;
    int unsigned           n_low;
    logic                  timeout_hit;
    logic                  set_multi;
    logic                  set_timeout;

    // Synchroniser stage: host pins into the p_in_clk domain, reset to idle bus levels
    always_ff @(posedge p_in_clk) begin
        if (p_in_rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            for (int i = 0; i < G_SYNC_STAGES; i++) cs_sync[i] <= '1;
        end else begin
            sclk_sync  <= {sclk_sync[G_SYNC_STAGES-2:0], bus.p_in_spi_clk};
            mosi_sync  <= {mosi_sync[G_SYNC_STAGES-2:0], bus.p_in_spi_mosi};
            sclk_prev  <= sclk_sync[G_SYNC_STAGES-1];
            cs_sync[0] <= bus.p_in_spi_cs;
            for (int i = 1; i < G_SYNC_STAGES; i++) cs_sync[i] <= cs_sync[i-1];
        end
    end

    assign cs_s      = cs_sync[G_SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[G_SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[G_SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    always_comb begin
        n_low       = count_low(cs_s);
        new_sel     = first_low(cs_s);
        new_mask    = G_CS_COUNT'(1) << new_sel;
        sel_mask    = G_CS_COUNT'(1) << sel;
        timeout_hit = (state == ST_ACTIVE) && (tout == TO_W'(G_TIMEOUT - 1));
        set_timeout = timeout_hit;
        // Any non-selected chip select low while routing counts as a collision
        set_multi   = ((state == ST_IDLE) && (n_low > 1)) ||
                      ((state == ST_ACTIVE) && ((~cs_s & ~sel_mask) != '0));
    end

    // Routing stage: registered target-facing outputs, one cycle after the synchronisers
    always_ff @(posedge p_in_clk) begin
        if (p_in_rst) begin
            state                 <= ST_IDLE;
            sel                   <= '0;
            bit_acc               <= '0;
            tout                  <= '0;
            bus.p_out_tgt_cs      <= '1;
            bus.p_out_tgt_clk     <= 1'b0;
            bus.p_out_tgt_mosi    <= 1'b0;
            bus.p_out_spi_miso    <= 1'b1;
            bus.p_out_active      <= '0;
            bus.p_out_xfer_done   <= 1'b0;
            bus.p_out_bit_cnt     <= '0;
            bus.p_out_err_multi   <= 1'b0;
            bus.p_out_err_timeout <= 1'b0;
        end else begin
            bus.p_out_xfer_done   <= 1'b0;
            bus.p_out_tgt_cs      <= '1;
            bus.p_out_tgt_clk     <= 1'b0;
            bus.p_out_tgt_mosi    <= 1'b0;
            bus.p_out_spi_miso    <= (state == ST_ACTIVE) ? bus.p_in_tgt_miso[sel] : 1'b1;
            bus.p_out_err_multi   <= set_multi | (bus.p_out_err_multi & ~bus.p_in_err_clr);
            bus.p_out_err_timeout <= set_timeout | (bus.p_out_err_timeout & ~bus.p_in_err_clr);

            case (state)
                ST_IDLE: begin
                    if (n_low == 1) begin
                        // Forward on the entry cycle so CS sees no extra latency
                        state              <= ST_ACTIVE;
                        sel                <= new_sel;
                        bus.p_out_active   <= new_mask;
                        bit_acc            <= '0;
                        tout               <= '0;
                        bus.p_out_tgt_cs   <= ~new_mask;
                        bus.p_out_tgt_clk  <= sclk_s;
                        bus.p_out_tgt_mosi <= mosi_s;
                    end else if (n_low > 1) begin
                        state <= ST_BLOCK;
                    end
                end
                ST_ACTIVE: begin
                    if (timeout_hit) begin
                        state            <= ST_BLOCK;
                        bus.p_out_active <= '0;
                    end else if (cs_s[sel]) begin
                        state               <= ST_IDLE;
                        bus.p_out_active    <= '0;
                        bus.p_out_bit_cnt   <= bit_acc;
                        bus.p_out_xfer_done <= 1'b1;
                    end else begin
                        bus.p_out_tgt_cs   <= ~sel_mask;
                        bus.p_out_tgt_clk  <= sclk_s;
                        bus.p_out_tgt_mosi <= mosi_s;
                        if (sclk_rise) begin
                            tout <= '0;
                            if (bit_acc != '1) bit_acc <= bit_acc + 1'b1;
                        end else begin
                            tout <= tout + 1'b1;
                        end
                    end
                end
                ST_BLOCK: begin
                    if (&cs_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cs_router.sv
// Self-checking bench for spi_cs_router (2 channels, 2 sync stages, timeout 64).
// Expected bit counts go into a queue as transfers are driven; completions are matched against it.
module tb_spi_cs_router;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_cs_router_if #(.G_CS_COUNT(2), .G_CNT_W(16)) bus ();

    spi_cs_router #(
        .G_CS_COUNT(2), .G_SYNC_STAGES(2), .G_TIMEOUT(64), .G_CNT_W(16)
    ) dut (
        .p_in_clk (clk),
        .p_in_rst (rst),
        .bus      (bus)
    );

    int n_pass   = 0;
    int n_checks = 0;

    logic [15:0] exp_q  [$];
    logic [15:0] done_q [$];

    int   cyc_n        = 0;
    int   tgt0_low     = 0;
    int   tgt1_low     = 0;
    int   tclk_rises   = 0;
    int   tclk_rise_at = 0;
    int   tcs0_rise_at = 0;
    logic tclk_prev    = 1'b0;
    logic tcs0_prev    = 1'b1;

    always @(negedge clk) begin
        cyc_n++;
        if (bus.p_out_xfer_done === 1'b1) done_q.push_back(bus.p_out_bit_cnt);
        if (bus.p_out_tgt_cs[0] === 1'b0) tgt0_low++;
        if (bus.p_out_tgt_cs[1] === 1'b0) tgt1_low++;
        if (bus.p_out_tgt_clk === 1'b1 && tclk_prev === 1'b0) begin
            tclk_rises++;
            tclk_rise_at = cyc_n;
        end
        if (bus.p_out_tgt_cs[0] === 1'b1 && tcs0_prev === 1'b0) tcs0_rise_at = cyc_n;
        tclk_prev = bus.p_out_tgt_clk;
        tcs0_prev = bus.p_out_tgt_cs[0];
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Host shifts MSB first at clk/8; the addressed target returns the same pattern on MISO
    task automatic send_bits(input int ch, input int n, input logic [7:0] pat,
                             output logic [7:0] cap);
        cap = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.p_in_spi_mosi     = pat[7 - (i % 8)];
            bus.p_in_tgt_miso[ch] = pat[7 - (i % 8)];
            step(4);
            cap = {cap[6:0], bus.p_out_spi_miso};
            bus.p_in_spi_clk = 1'b1;
            step(4);
            bus.p_in_spi_clk = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_q.size() != 0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        n_checks++; if (bus.p_out_tgt_cs !== 2'b11) $display("FAIL rst_tgt_cs got %b want 11", bus.p_out_tgt_cs); else n_pass++;
        n_checks++; if (bus.p_out_tgt_clk !== 1'b0) $display("FAIL rst_tgt_clk got %b want 0", bus.p_out_tgt_clk); else n_pass++;
        n_checks++; if (bus.p_out_tgt_mosi !== 1'b0) $display("FAIL rst_tgt_mosi got %b want 0", bus.p_out_tgt_mosi); else n_pass++;
        n_checks++; if (bus.p_out_spi_miso !== 1'b1) $display("FAIL rst_miso got %b want 1", bus.p_out_spi_miso); else n_pass++;
        n_checks++; if (bus.p_out_active !== 2'b00) $display("FAIL rst_active got %b want 00", bus.p_out_active); else n_pass++;
        n_checks++; if (bus.p_out_xfer_done !== 1'b0) $display("FAIL rst_done got %b want 0", bus.p_out_xfer_done); else n_pass++;
        n_checks++; if (bus.p_out_bit_cnt !== 16'd0) $display("FAIL rst_bit_cnt got %0d want 0", bus.p_out_bit_cnt); else n_pass++;
        n_checks++; if ({bus.p_out_err_multi, bus.p_out_err_timeout} !== 2'b00) $display("FAIL rst_err got %b want 00", {bus.p_out_err_multi, bus.p_out_err_timeout}); else n_pass++;
    endtask

    task automatic test_clean_transfer;
        int t1, r0;
        bit ok;
        logic [7:0] cap;
        logic [15:0] e, a;
        t1 = tgt1_low;
        r0 = tclk_rises;
        exp_q.push_back(16'd40);
        bus.p_in_spi_mosi  = 1'b1;
        bus.p_in_spi_cs[0] = 1'b0;
        step(2);
        n_checks++; if (bus.p_out_tgt_cs !== 2'b11) $display("FAIL clean_cs_early got %b want 11", bus.p_out_tgt_cs); else n_pass++;
        step(1);
        n_checks++; if (bus.p_out_tgt_cs !== 2'b10) $display("FAIL clean_cs_latency got %b want 10", bus.p_out_tgt_cs); else n_pass++;
        n_checks++; if (bus.p_out_active !== 2'b01) $display("FAIL clean_active got %b want 01", bus.p_out_active); else n_pass++;
        n_checks++; if (bus.p_out_tgt_mosi !== 1'b1) $display("FAIL clean_mosi got %b want 1", bus.p_out_tgt_mosi); else n_pass++;
        step(1);
        send_bits(0, 40, 8'h3C, cap);
        n_checks++; if (bus.p_out_active !== 2'b01) $display("FAIL clean_active_end got %b want 01", bus.p_out_active); else n_pass++;
        step(4);
        bus.p_in_spi_cs[0] = 1'b1;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("FAIL clean_done got no pulse want bit_cnt 40");
        else begin
            e = exp_q.pop_front(); a = done_q.pop_front();
            if (a !== e) $display("FAIL clean_bit_cnt got %0d want %0d", a, e); else n_pass++;
        end
        step(6);
        n_checks++; if (done_q.size() != 0) $display("FAIL clean_single_pulse got %0d extra want 0", done_q.size()); else n_pass++;
        n_checks++; if (tgt1_low - t1 != 0) $display("FAIL clean_cs1_idle got %0d low cycles want 0", tgt1_low - t1); else n_pass++;
        n_checks++; if (tclk_rises - r0 != 40) $display("FAIL clean_sclk_edges got %0d want 40", tclk_rises - r0); else n_pass++;
        n_checks++; if (bus.p_out_active !== 2'b00) $display("FAIL clean_active_after got %b want 00", bus.p_out_active); else n_pass++;
    endtask

    task automatic test_miso_routing;
        bit ok;
        logic [7:0] cap;
        logic [15:0] e, a;
        bus.p_in_tgt_miso = 2'b00;
        step(2);
        n_checks++; if (bus.p_out_spi_miso !== 1'b1) $display("FAIL miso_idle_before got %b want 1", bus.p_out_spi_miso); else n_pass++;
        exp_q.push_back(16'd8);
        bus.p_in_spi_cs[1] = 1'b0;
        step(3);
        n_checks++; if (bus.p_out_active !== 2'b10) $display("FAIL miso_active got %b want 10", bus.p_out_active); else n_pass++;
        step(1);
        send_bits(1, 8, 8'hA5, cap);
        n_checks++; if (cap !== 8'hA5) $display("FAIL miso_byte got %h want a5", cap); else n_pass++;
        step(4);
        bus.p_in_spi_cs[1] = 1'b1;
        bus.p_in_tgt_miso  = 2'b00;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("FAIL miso_done got no pulse want bit_cnt 8");
        else begin
            e = exp_q.pop_front(); a = done_q.pop_front();
            if (a !== e) $display("FAIL miso_bit_cnt got %0d want %0d", a, e); else n_pass++;
        end
        step(4);
        n_checks++; if (bus.p_out_spi_miso !== 1'b1) $display("FAIL miso_idle_after got %b want 1", bus.p_out_spi_miso); else n_pass++;
    endtask

    task automatic test_collision;
        int t1;
        bit ok;
        logic [7:0] cap;
        logic [15:0] e, a;
        t1 = tgt1_low;
        exp_q.push_back(16'd20);
        bus.p_in_spi_cs[0] = 1'b0;
        step(4);
        send_bits(0, 10, 8'h5A, cap);
        bus.p_in_spi_cs[1] = 1'b0;
        send_bits(0, 10, 8'h96, cap);
        bus.p_in_spi_cs[1] = 1'b1;
        step(4);
        bus.p_in_spi_cs[0] = 1'b1;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("FAIL coll_done got no pulse want bit_cnt 20");
        else begin
            e = exp_q.pop_front(); a = done_q.pop_front();
            if (a !== e) $display("FAIL coll_bit_cnt got %0d want %0d", a, e); else n_pass++;
        end
        n_checks++; if (tgt1_low - t1 != 0) $display("FAIL coll_cs1_forwarded got %0d low cycles want 0", tgt1_low - t1); else n_pass++;
        n_checks++; if (bus.p_out_err_multi !== 1'b1) $display("FAIL coll_err_multi got %b want 1", bus.p_out_err_multi); else n_pass++;
        step(4);
    endtask

    task automatic test_block;
        int t0, t1, r0;
        bit ok;
        logic [7:0] cap;
        logic [15:0] e, a;
        bus.p_in_err_clr = 1'b1;
        step(1);
        bus.p_in_err_clr = 1'b0;
        t0 = tgt0_low; t1 = tgt1_low; r0 = tclk_rises;
        bus.p_in_spi_cs = 2'b00;
        step(4);
        send_bits(0, 2, 8'hC0, cap);
        n_checks++; if (bus.p_out_tgt_cs !== 2'b11) $display("FAIL block_tgt_cs got %b want 11", bus.p_out_tgt_cs); else n_pass++;
        n_checks++; if (bus.p_out_err_multi !== 1'b1) $display("FAIL block_err_multi got %b want 1", bus.p_out_err_multi); else n_pass++;
        n_checks++; if (bus.p_out_active !== 2'b00) $display("FAIL block_active got %b want 00", bus.p_out_active); else n_pass++;
        bus.p_in_spi_cs[0] = 1'b1;
        step(8);
        n_checks++; if ((tgt0_low - t0) + (tgt1_low - t1) != 0) $display("FAIL block_cs_leak got %0d low cycles want 0", (tgt0_low - t0) + (tgt1_low - t1)); else n_pass++;
        n_checks++; if (tclk_rises - r0 != 0) $display("FAIL block_sclk_leak got %0d edges want 0", tclk_rises - r0); else n_pass++;
        bus.p_in_spi_cs[1] = 1'b1;
        step(4);
        exp_q.push_back(16'd4);
        bus.p_in_spi_cs[0] = 1'b0;
        step(4);
        send_bits(0, 4, 8'hF0, cap);
        step(4);
        bus.p_in_spi_cs[0] = 1'b1;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("FAIL block_exit_done got no pulse want bit_cnt 4");
        else begin
            e = exp_q.pop_front(); a = done_q.pop_front();
            if (a !== e) $display("FAIL block_exit_bit_cnt got %0d want %0d", a, e); else n_pass++;
        end
        step(4);
    endtask

    task automatic test_timeout;
        bit ok;
        logic [7:0] cap;
        logic [15:0] e, a;
        bus.p_in_spi_cs[0] = 1'b0;
        step(4);
        send_bits(0, 8, 8'h81, cap);
        step(100);
        n_checks++; if (tcs0_rise_at - tclk_rise_at != 64) $display("FAIL tout_release_delay got %0d want 64", tcs0_rise_at - tclk_rise_at); else n_pass++;
        n_checks++; if (bus.p_out_err_timeout !== 1'b1) $display("FAIL tout_err got %b want 1", bus.p_out_err_timeout); else n_pass++;
        n_checks++; if (done_q.size() != 0) $display("FAIL tout_no_done got %0d pulses want 0", done_q.size()); else n_pass++;
        n_checks++; if (bus.p_out_bit_cnt !== 16'd4) $display("FAIL tout_bit_cnt_kept got %0d want 4", bus.p_out_bit_cnt); else n_pass++;
        n_checks++; if (bus.p_out_tgt_cs !== 2'b11) $display("FAIL tout_tgt_cs got %b want 11", bus.p_out_tgt_cs); else n_pass++;
        bus.p_in_spi_cs[0] = 1'b1;
        step(6);
        exp_q.push_back(16'd5);
        bus.p_in_spi_cs[0] = 1'b0;
        step(4);
        send_bits(0, 5, 8'h6E, cap);
        step(4);
        bus.p_in_spi_cs[0] = 1'b1;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("FAIL tout_recover_done got no pulse want bit_cnt 5");
        else begin
            e = exp_q.pop_front(); a = done_q.pop_front();
            if (a !== e) $display("FAIL tout_recover_bit_cnt got %0d want %0d", a, e); else n_pass++;
        end
        n_checks++; if (bus.p_out_err_timeout !== 1'b1) $display("FAIL tout_sticky got %b want 1", bus.p_out_err_timeout); else n_pass++;
        step(4);
    endtask

    task automatic test_err_clear;
        bus.p_in_err_clr = 1'b1;
        step(1);
        bus.p_in_err_clr = 1'b0;
        step(1);
        n_checks++; if ({bus.p_out_err_multi, bus.p_out_err_timeout} !== 2'b00) $display("FAIL clr_flags got %b want 00", {bus.p_out_err_multi, bus.p_out_err_timeout}); else n_pass++;
        // Collision is seen on the third edge after the pins drop; clear is held across it
        bus.p_in_spi_cs = 2'b00;
        step(1);
        bus.p_in_err_clr = 1'b1;
        step(2);
        bus.p_in_err_clr = 1'b0;
        step(1);
        n_checks++; if (bus.p_out_err_multi !== 1'b1) $display("FAIL clr_vs_set got %b want 1", bus.p_out_err_multi); else n_pass++;
        n_checks++; if (bus.p_out_err_timeout !== 1'b0) $display("FAIL clr_timeout_stays got %b want 0", bus.p_out_err_timeout); else n_pass++;
        bus.p_in_spi_cs = 2'b11;
        step(6);
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [7:0] cap;
        logic [15:0] e, a;
        bus.p_in_spi_cs[0] = 1'b0;
        step(4);
        send_bits(0, 12, 8'hB7, cap);
        bus.p_in_spi_clk = 1'b1;
        step(3);
        n_checks++; if (bus.p_out_tgt_clk !== 1'b1) $display("FAIL rmid_pre_clk got %b want 1", bus.p_out_tgt_clk); else n_pass++;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.p_in_spi_cs   = 2'b11;
        bus.p_in_spi_clk  = 1'b0;
        bus.p_in_spi_mosi = 1'b0;
        n_checks++; if (bus.p_out_tgt_cs !== 2'b11) $display("FAIL rmid_tgt_cs got %b want 11", bus.p_out_tgt_cs); else n_pass++;
        n_checks++; if (bus.p_out_tgt_clk !== 1'b0) $display("FAIL rmid_tgt_clk got %b want 0", bus.p_out_tgt_clk); else n_pass++;
        n_checks++; if (bus.p_out_spi_miso !== 1'b1) $display("FAIL rmid_miso got %b want 1", bus.p_out_spi_miso); else n_pass++;
        n_checks++; if (bus.p_out_active !== 2'b00) $display("FAIL rmid_active got %b want 00", bus.p_out_active); else n_pass++;
        n_checks++; if (bus.p_out_bit_cnt !== 16'd0) $display("FAIL rmid_bit_cnt got %0d want 0", bus.p_out_bit_cnt); else n_pass++;
        n_checks++; if (bus.p_out_err_multi !== 1'b0) $display("FAIL rmid_err_multi got %b want 0", bus.p_out_err_multi); else n_pass++;
        step(6);
        exp_q.push_back(16'd6);
        bus.p_in_spi_cs[0] = 1'b0;
        step(4);
        send_bits(0, 6, 8'h42, cap);
        step(4);
        bus.p_in_spi_cs[0] = 1'b1;
        wait_done(ok);
        n_checks++;
        if (!ok) $display("FAIL rmid_after_done got no pulse want bit_cnt 6");
        else begin
            e = exp_q.pop_front(); a = done_q.pop_front();
            if (a !== e) $display("FAIL rmid_after_bit_cnt got %0d want %0d", a, e); else n_pass++;
        end
    endtask

    initial begin
        bus.p_in_spi_clk  = 1'b0;
        bus.p_in_spi_cs   = 2'b11;
        bus.p_in_spi_mosi = 1'b0;
        bus.p_in_tgt_miso = 2'b00;
        bus.p_in_err_clr  = 1'b0;
        rst = 1'b1;
        step(3);
        test_reset;
        rst = 1'b0;
        step(2);
        test_clean_transfer;
        test_miso_routing;
        test_collision;
        test_block;
        test_timeout;
        test_err_clear;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
